cp0_unit: RTL and testbench

- Coprocessor-0 responder for the multi-cycle MIPS54 core; the other end of the CPU's cpu_cp0_*/cp0_cpu_* interface.
- Holds Status, Cause and EPC, plus Count and Compare when the timer option is compiled in.
- Services mfc0/mtc0 reads and writes, records exception entry, and restores state on eret.
- Supplies the PC redirect target (exc_addr) and the live Status word back to the core's controller.

---
 rtl/cp0_pkg.sv | 20 ++
 rtl/cp0_unit_if.sv | 35 +++
 rtl/cp0_timer.sv | 31 +++
 rtl/cp0_unit.sv | 128 ++++++++++++
 tb/tb_cp0_unit.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - CP0 register indices, exception codes and shared constants
package cp0_pkg;

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_STATUS  = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;

    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_BREAK   = 5'd9;
    localparam logic [4:0] EXC_TEQ     = 5'd13;

    // Status is a stack of 5-bit slots; exception entry pushes, eret pops
    localparam int STATUS_SHIFT = 5;

    // Bit of Cause that flags a Count/Compare match
    localparam int CAUSE_TIMER_BIT = 15;

endpackage

// File: rtl/cp0_unit_if.sv
// rtl/cp0_unit_if.sv - CPU <-> CP0 request/response signal bundle
interface cp0_unit_if;

    logic        cpu_cp0_mfc0;
    logic        cpu_cp0_mtc0;
    logic [31:0] cpu_cp0_pc;
    logic [4:0]  cpu_cp0_rd;
    logic [31:0] cpu_cp0_wdata;
    logic        cpu_cp0_exception;
    logic        cpu_cp0_eret;
    logic [4:0]  cpu_cp0_cause;

    logic [31:0] cp0_cpu_rdata;
    logic [31:0] cp0_cpu_status;
    logic [31:0] cp0_cpu_exc_addr;
    logic [2:0]  cp0_cpu_exc_depth;
    logic        cp0_cpu_irq;

    // The core drives requests and consumes CP0 state
    modport master (
        output cpu_cp0_mfc0, cpu_cp0_mtc0, cpu_cp0_pc, cpu_cp0_rd, cpu_cp0_wdata,
               cpu_cp0_exception, cpu_cp0_eret, cpu_cp0_cause,
        input  cp0_cpu_rdata, cp0_cpu_status, cp0_cpu_exc_addr, cp0_cpu_exc_depth,
               cp0_cpu_irq
    );

    // CP0 answers the core
    modport slave (
        input  cpu_cp0_mfc0, cpu_cp0_mtc0, cpu_cp0_pc, cpu_cp0_rd, cpu_cp0_wdata,
               cpu_cp0_exception, cpu_cp0_eret, cpu_cp0_cause,
        output cp0_cpu_rdata, cp0_cpu_status, cp0_cpu_exc_addr, cp0_cpu_exc_depth,
               cp0_cpu_irq
    );

endinterface

// File: rtl/cp0_timer.sv
// rtl/cp0_timer.sv - Count/Compare timer, present only when CP0_TIMER_EN is defined
`ifdef CP0_TIMER_EN
module cp0_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        hit
);

    // Free-running counter; a software load overrides the increment
    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            compare <= '0;
        end else begin
            count <= count_we ? wdata : count + 32'd1;
            if (compare_we) begin
                compare <= wdata;
            end
        end
    end

    // A zero Compare means the timer is disarmed
    assign hit = (compare != 32'd0) && (count == compare);

endmodule
`endif

// File: rtl/cp0_unit.sv
// rtl/cp0_unit.sv - MIPS54 coprocessor-0 (Status/Cause/EPC, timer under CP0_TIMER_EN)
module cp0_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'h0040_0004,
    parameter logic [31:0] RESET_STATUS = 32'h0000_000F,
    parameter int          MAX_DEPTH    = 6
) (
    input  logic       clk,
    input  logic       reset,
    cp0_unit_if.slave  bus
);

    localparam logic [2:0] DEPTH_LIMIT = 3'(MAX_DEPTH);

    logic [31:0] status_q;
    logic [31:0] cause_q;
    logic [31:0] epc_q;
    logic [2:0]  depth_q;
    logic [31:0] cause_d;

    logic        exc;
    logic        eret;
    logic        wr_en;
    logic [31:0] count_val;
    logic [31:0] compare_val;
    logic        compare_we;
    logic        timer_hit;

    // mfc0 is advisory: reads are always live
    logic        unused_mfc0;
    assign unused_mfc0 = bus.cpu_cp0_mfc0;

    // Exception beats eret beats mtc0; a losing mtc0 is dropped whatever its target
    assign exc   = bus.cpu_cp0_exception;
    assign eret  = bus.cpu_cp0_eret & ~exc;
    assign wr_en = bus.cpu_cp0_mtc0 & ~bus.cpu_cp0_exception & ~bus.cpu_cp0_eret;

`ifdef CP0_TIMER_EN
    logic count_we;
    assign count_we   = wr_en && (bus.cpu_cp0_rd == REG_COUNT);
    assign compare_we = wr_en && (bus.cpu_cp0_rd == REG_COMPARE);

    cp0_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .count_we   (count_we),
        .compare_we (compare_we),
        .wdata      (bus.cpu_cp0_wdata),
        .count      (count_val),
        .compare    (compare_val),
        .hit        (timer_hit)
    );
`else
    assign count_val   = '0;
    assign compare_val = '0;
    assign compare_we  = 1'b0;
    assign timer_hit   = 1'b0;
`endif

    // Next Cause: exception code insert or software write, then the sticky timer flag
    always_comb begin
        cause_d = cause_q;
        if (exc) begin
            cause_d = {cause_q[31:7], bus.cpu_cp0_cause, 2'b00};
        end else if (wr_en && (bus.cpu_cp0_rd == REG_CAUSE)) begin
            cause_d = bus.cpu_cp0_wdata;
        end
        if (compare_we) begin
            cause_d[CAUSE_TIMER_BIT] = 1'b0;
        end else if (timer_hit) begin
            cause_d[CAUSE_TIMER_BIT] = 1'b1;
        end
    end

    // Architectural state: exception push, eret pop, or a plain register write
    always_ff @(posedge clk) begin
        if (reset) begin
            status_q <= RESET_STATUS;
            cause_q  <= '0;
            epc_q    <= '0;
            depth_q  <= '0;
        end else begin
            cause_q <= cause_d;
            if (exc) begin
                epc_q    <= bus.cpu_cp0_pc;
                // Past the limit the oldest slot falls off the top; depth stays pinned
                status_q <= status_q << STATUS_SHIFT;
                depth_q  <= (depth_q >= DEPTH_LIMIT) ? DEPTH_LIMIT : depth_q + 3'd1;
            end else if (eret) begin
                if (depth_q != 3'd0) begin
                    status_q <= status_q >> STATUS_SHIFT;
                    depth_q  <= depth_q - 3'd1;
                end
            end else if (wr_en) begin
                case (bus.cpu_cp0_rd)
                    REG_STATUS: status_q <= bus.cpu_cp0_wdata;
                    REG_EPC:    epc_q    <= bus.cpu_cp0_wdata;
                    default:    ;
                endcase
            end
        end
    end

    // Register read port, zero latency; unimplemented indices read as zero
    always_comb begin
        case (bus.cpu_cp0_rd)
            REG_COUNT:   bus.cp0_cpu_rdata = count_val;
            REG_COMPARE: bus.cp0_cpu_rdata = compare_val;
            REG_STATUS:  bus.cp0_cpu_rdata = status_q;
            REG_CAUSE:   bus.cp0_cpu_rdata = cause_q;
            REG_EPC:     bus.cp0_cpu_rdata = epc_q;
            default:     bus.cp0_cpu_rdata = '0;
        endcase
    end

    // The core latches the redirect in the same cycle as the pulse
    assign bus.cp0_cpu_exc_addr  = bus.cpu_cp0_eret ? epc_q : EXC_VECTOR;
    assign bus.cp0_cpu_status    = status_q;
    assign bus.cp0_cpu_exc_depth = depth_q;

`ifdef CP0_TIMER_EN
    assign bus.cp0_cpu_irq = cause_q[CAUSE_TIMER_BIT] & status_q[0];
`else
    assign bus.cp0_cpu_irq = 1'b0;
`endif

endmodule

// File: tb/tb_cp0_unit.sv
// tb/tb_cp0_unit.sv - randomized model-checked bench for cp0_unit (timer cases under CP0_TIMER_EN)
module tb_cp0_unit;

`ifdef CP0_TIMER_EN
    localparam bit TIMER_ON = 1'b1;
`else
    localparam bit TIMER_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cp0_unit_if bus ();

    cp0_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference state, written from the architectural rules
    logic [31:0] m_status, m_cause, m_epc, m_count, m_compare, n_cause;
    int          m_depth;
    bit          m_hit, m_wr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] idx);
        case (idx)
            5'd12:   return m_status;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd9:    return TIMER_ON ? m_count : 32'd0;
            5'd11:   return TIMER_ON ? m_compare : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Reference update at each rising edge from the inputs held during the cycle
    always @(posedge clk) begin
        if (reset) begin
            m_status = 32'h0000_000F; m_cause = 0; m_epc = 0; m_depth = 0;
            m_count = 0; m_compare = 0;
        end else begin
            m_hit   = TIMER_ON && (m_compare != 0) && (m_count == m_compare);
            m_wr    = bus.cpu_cp0_mtc0 && !bus.cpu_cp0_exception && !bus.cpu_cp0_eret;
            n_cause = m_cause;
            if (bus.cpu_cp0_exception) begin
                m_epc    = bus.cpu_cp0_pc;
                n_cause  = (m_cause & 32'hFFFF_FF80) + 32'(bus.cpu_cp0_cause) * 4;
                m_status = m_status * 32;
                if (m_depth < 6) m_depth = m_depth + 1;
            end else if (bus.cpu_cp0_eret) begin
                if (m_depth > 0) begin
                    m_status = m_status / 32;
                    m_depth  = m_depth - 1;
                end
            end else if (m_wr) begin
                if (bus.cpu_cp0_rd == 12) m_status = bus.cpu_cp0_wdata;
                if (bus.cpu_cp0_rd == 13) n_cause  = bus.cpu_cp0_wdata;
                if (bus.cpu_cp0_rd == 14) m_epc    = bus.cpu_cp0_wdata;
            end
            if (TIMER_ON) begin
                if (m_wr && bus.cpu_cp0_rd == 9) m_count = bus.cpu_cp0_wdata;
                else m_count = m_count + 1;
                if (m_wr && bus.cpu_cp0_rd == 11) begin
                    m_compare   = bus.cpu_cp0_wdata;
                    n_cause[15] = 1'b0;
                end else if (m_hit) begin
                    n_cause[15] = 1'b1;
                end
            end
            m_cause = n_cause;
        end
    end

    // Every-cycle comparison of all outputs against the reference
    always @(negedge clk) begin
        if (chk_en) begin
            chk("rdata", bus.cp0_cpu_rdata, m_read(bus.cpu_cp0_rd));
            chk("status", bus.cp0_cpu_status, m_status);
            chk("exc_addr", bus.cp0_cpu_exc_addr, bus.cpu_cp0_eret ? m_epc : 32'h0040_0004);
            chk("depth", 32'(bus.cp0_cpu_exc_depth), 32'(m_depth));
            chk("irq", 32'(bus.cp0_cpu_irq), TIMER_ON ? 32'(m_cause[15] & m_status[0]) : 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.cpu_cp0_mfc0 = 0; bus.cpu_cp0_mtc0 = 0; bus.cpu_cp0_exception = 0;
        bus.cpu_cp0_eret = 0;
    endtask

    task automatic do_reset();
        quiet();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic mtc0(input logic [4:0] rd, input logic [31:0] d);
        quiet();
        bus.cpu_cp0_mtc0 = 1; bus.cpu_cp0_rd = rd; bus.cpu_cp0_wdata = d;
    endtask

    task automatic except(input logic [31:0] pc, input logic [4:0] code);
        quiet();
        bus.cpu_cp0_exception = 1; bus.cpu_cp0_pc = pc; bus.cpu_cp0_cause = code;
    endtask

    initial begin
        bus.cpu_cp0_mfc0 = 0; bus.cpu_cp0_mtc0 = 0; bus.cpu_cp0_pc = 0;
        bus.cpu_cp0_rd = 0; bus.cpu_cp0_wdata = 0; bus.cpu_cp0_exception = 0;
        bus.cpu_cp0_eret = 0; bus.cpu_cp0_cause = 0;
        do_reset();
        chk_en = 1'b1;

        // Reset state
        bus.cpu_cp0_rd = 12; #1 chk("lit_rst_status", bus.cp0_cpu_rdata, 32'h0000_000F);
        bus.cpu_cp0_rd = 13; #1 chk("lit_rst_cause", bus.cp0_cpu_rdata, 32'h0);
        bus.cpu_cp0_rd = 14; #1 chk("lit_rst_epc", bus.cp0_cpu_rdata, 32'h0);
        chk("lit_rst_vector", bus.cp0_cpu_exc_addr, 32'h0040_0004);
        chk("lit_rst_depth", 32'(bus.cp0_cpu_exc_depth), 32'd0);
        step();

        // mtc0 EPC: old value visible in the write cycle
        mtc0(14, 32'h1234_5678);
        #1 chk("lit_mtc0_same", bus.cp0_cpu_rdata, 32'h0);
        step(); quiet();
        #1 chk("lit_mtc0_next", bus.cp0_cpu_rdata, 32'h1234_5678);

        // syscall exception
        except(32'h0040_0100, 5'd8);
        step(); quiet();
        bus.cpu_cp0_rd = 14; #1 chk("lit_exc_epc", bus.cp0_cpu_rdata, 32'h0040_0100);
        bus.cpu_cp0_rd = 13; #1 chk("lit_exc_cause", bus.cp0_cpu_rdata, 32'h0000_0020);
        chk("lit_exc_status", bus.cp0_cpu_status, 32'h0000_01E0);
        chk("lit_exc_depth", 32'(bus.cp0_cpu_exc_depth), 32'd1);

        // eret, then an eret with nothing to pop
        bus.cpu_cp0_eret = 1;
        #1 chk("lit_eret_addr", bus.cp0_cpu_exc_addr, 32'h0040_0100);
        step(); quiet();
        #1 chk("lit_eret_status", bus.cp0_cpu_status, 32'h0000_000F);
        chk("lit_eret_depth", 32'(bus.cp0_cpu_exc_depth), 32'd0);
        bus.cpu_cp0_eret = 1;
        step(); quiet();
        #1 chk("lit_eret2_status", bus.cp0_cpu_status, 32'h0000_000F);
        chk("lit_eret2_depth", 32'(bus.cp0_cpu_exc_depth), 32'd0);

        // Nesting saturation
        do_reset();
        for (int i = 0; i < 7; i++) begin
            except(32'h0040_1000 + 32'(i * 4), 5'd9);
            step();
        end
        quiet();
        #1 chk("lit_sat_depth", 32'(bus.cp0_cpu_exc_depth), 32'd6);
        chk("lit_sat_status", bus.cp0_cpu_status, 32'h0);

        // Exception + eret + mtc0 together: only the exception lands
        except(32'h0040_0200, 5'd13);
        bus.cpu_cp0_eret = 1; bus.cpu_cp0_mtc0 = 1;
        bus.cpu_cp0_rd = 14; bus.cpu_cp0_wdata = 32'hDEAD_BEEF;
        step(); quiet();
        #1 chk("lit_prio_epc", bus.cp0_cpu_rdata, 32'h0040_0200);
        chk("lit_prio_depth", 32'(bus.cp0_cpu_exc_depth), 32'd6);

`ifdef CP0_TIMER_EN
        do_reset();
        mtc0(11, 32'd5); step();
        mtc0(9, 32'd0);  step(); quiet();
        begin
            int n;
            n = 0;
            while (!bus.cp0_cpu_irq && n < 20) begin
                step();
                n++;
            end
            chk("lit_timer_irq", 32'(bus.cp0_cpu_irq), 32'd1);
            bus.cpu_cp0_rd = 13; #1 chk("lit_timer_cause15", 32'(bus.cp0_cpu_rdata[15]), 32'd1);
        end
        mtc0(11, 32'd100); step(); quiet();
        #1 chk("lit_timer_clear", 32'(bus.cp0_cpu_irq), 32'd0);
`endif

        // Randomized traffic against the reference
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic [4:0] picks [6];
            logic [4:0] codes [3];
            picks = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0};
            codes = '{5'd8, 5'd9, 5'd13};
            picks[5] = 5'($urandom_range(0, 31));
            bus.cpu_cp0_rd        = picks[$urandom_range(0, 5)];
            bus.cpu_cp0_mfc0      = 1'($urandom_range(0, 1));
            bus.cpu_cp0_mtc0      = ($urandom_range(0, 2) == 0);
            bus.cpu_cp0_exception = ($urandom_range(0, 7) == 0);
            bus.cpu_cp0_eret      = ($urandom_range(0, 5) == 0);
            bus.cpu_cp0_cause     = codes[$urandom_range(0, 2)];
            bus.cpu_cp0_pc        = $urandom;
            bus.cpu_cp0_wdata     = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            step();
        end
        quiet();
        step();
        chk_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
